// File: rtl/rom_stream_reader_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// rom_stream_pkg : shared types and defaults for rom_stream_reader
// Rev 1.0
// ------------------------------------------------------------------
package rom_stream_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int ROM_LATENCY        = 1;
   localparam int DEF_ADDR_W         = 4;
   localparam int DEF_DATA_W         = 4;
   localparam int DEF_FIFO_DEPTH     = 4;

endpackage
`default_nettype wire

// File: rtl/rom_stream_reader_stream_fifo.sv
`default_nettype none
// ------------------------------------------------------------------
// stream_fifo : circular buffer, registered storage, combinational head
// Rev 1.0
// ------------------------------------------------------------------
module stream_fifo #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        head_data,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    empty,
   output logic                    full
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == (PTR_W+1)'(DEPTH));
   assign do_pop    = pop & ~empty;
   assign do_push   = push & (~full | do_pop);
   assign head_data = mem_q[rd_ptr_q];
   assign count     = count_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Upstream credit accounting must never let a push reach a full buffer.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule
`default_nettype wire

// File: rtl/rom_stream_reader.sv
`default_nettype none
// ------------------------------------------------------------------
// rom_stream_reader : burst reader for a 1-cycle sync ROM, valid/ready out
// Rev 1.0
// ------------------------------------------------------------------
module rom_stream_reader
   import rom_stream_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W:0]   len,
   output logic              busy,
   output logic              done,
   output logic              rom_en,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
   logic [ADDR_W:0]     remaining_q, remaining_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                rom_en_q, rom_en_d;
   logic                rom_last_q, rom_last_d;
   logic                inflight_q, inflight_d;
   logic                inflight_last_q, inflight_last_d;
   logic                zero_len_q, zero_len_d;

   logic [CNT_W-1:0]    fifo_count;
   logic                fifo_empty;
   logic                fifo_full;
   logic [DATA_W:0]     fifo_head;
   logic [CNT_W:0]      outstanding;
   logic                pop;
   logic                issue;

   assign pop = out_valid & out_ready;

   // A read on the ROM bus this cycle and one returning data both hold a slot.
   assign outstanding = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q}
                      + {{CNT_W{1'b0}}, rom_en_q};
   assign issue = (state_q == READ) && (remaining_q != '0) && !fifo_full
               && (outstanding < (CNT_W+1)'(FIFO_DEPTH));

   always_comb begin
      state_d         = state_q;
      addr_d          = addr_q;
      rom_addr_d      = rom_addr_q;
      remaining_d     = remaining_q;
      busy_d          = busy_q;
      zero_len_d      = zero_len_q;
      done_d          = 1'b0;
      rom_en_d        = 1'b0;
      rom_last_d      = 1'b0;
      inflight_d      = rom_en_q;
      inflight_last_d = rom_last_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               busy_d = 1'b1;
               if (len == '0) begin
                  zero_len_d = 1'b1;
                  state_d    = DRAIN;
               end else begin
                  zero_len_d  = 1'b0;
                  addr_d      = start_addr;
                  remaining_d = len;
                  state_d     = READ;
               end
            end
         end
         READ: begin
            if (issue) begin
               rom_en_d    = 1'b1;
               rom_addr_d  = addr_q;
               rom_last_d  = (remaining_q == (ADDR_W+1)'(1));
               addr_d      = addr_q + 1'b1;
               remaining_d = remaining_q - 1'b1;
               if (remaining_q == (ADDR_W+1)'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            // Popping the tagged word means nothing else is queued or in flight.
            if (zero_len_q || (pop && out_last)) begin
               done_d     = 1'b1;
               busy_d     = 1'b0;
               zero_len_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         rom_addr_q      <= '0;
         remaining_q     <= '0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         rom_en_q        <= 1'b0;
         rom_last_q      <= 1'b0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         zero_len_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         rom_addr_q      <= rom_addr_d;
         remaining_q     <= remaining_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         rom_en_q        <= rom_en_d;
         rom_last_q      <= rom_last_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         zero_len_q      <= zero_len_d;
      end
   end

   stream_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data ({inflight_last_q, rom_data}),
      .pop       (pop),
      .head_data (fifo_head),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign rom_en    = rom_en_q;
   assign rom_addr  = rom_addr_q;
   assign out_valid = ~fifo_empty;
   assign out_data  = fifo_head[DATA_W-1:0];
   assign out_last  = fifo_head[DATA_W];

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_rom_stream_reader : bench for rom_stream_reader with a mem[a]=a^A ROM
// Rev 1.0
// ------------------------------------------------------------------
module tb_rom_stream_reader;
   localparam int ADDR_W     = 4;
   localparam int DATA_W     = 4;
   localparam int FIFO_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [ADDR_W-1:0] start_addr;
   logic [ADDR_W:0]   len;
   logic              busy;
   logic              done;
   logic              rom_en;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data = '0;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_last;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rom_stream_reader #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .start_addr (start_addr),
      .len        (len),
      .busy       (busy),
      .done       (done),
      .rom_en     (rom_en),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_last   (out_last)
   );

   // ROM model: synchronous read, contents a XOR 4'hA
   always @(posedge clk) begin
      if (rom_en) rom_data <= rom_addr ^ 4'hA;
   end

   // Monitor: logs bus activity on the falling edge
   logic       clr_req = 1'b0;
   int         cyc = 0;
   logic [3:0] mon_addr[$];
   int         mon_en_cyc[$];
   logic [3:0] mon_data[$];
   logic [3:0] mon_last[$];
   int         mon_hs_cyc[$];
   int         done_cnt, done_cyc, busy_cnt, first_busy_cyc, last_hs_cyc;
   bit         valid_seen, unstable, busy_at_last, busy_at_done;
   bit         prev_stall;
   logic [3:0] prev_data;
   logic       prev_last;

   always @(negedge clk) begin
      cyc++;
      if (clr_req || rst) begin
         mon_addr.delete(); mon_en_cyc.delete(); mon_data.delete();
         mon_last.delete(); mon_hs_cyc.delete();
         done_cnt = 0; done_cyc = -1; busy_cnt = 0; first_busy_cyc = -1; last_hs_cyc = -1;
         valid_seen = 0; unstable = 0; busy_at_last = 0; busy_at_done = 1; prev_stall = 0;
      end else begin
         if (rom_en) begin mon_addr.push_back(rom_addr); mon_en_cyc.push_back(cyc); end
         if (out_valid) valid_seen = 1;
         if (prev_stall && (!out_valid || out_data !== prev_data || out_last !== prev_last)) unstable = 1;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
         if (out_valid && out_ready) begin
            mon_data.push_back(out_data);
            mon_last.push_back({3'b000, out_last});
            mon_hs_cyc.push_back(cyc);
            if (out_last) begin last_hs_cyc = cyc; busy_at_last = busy; end
         end
         if (busy) begin
            busy_cnt++;
            if (first_busy_cyc < 0) first_busy_cyc = cyc;
         end
         if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
      end
   end

   // Reference model: burst (a, n) reads a, a+1, ... mod 16, data = addr ^ A
   logic [3:0] exp_addr[$];
   logic [3:0] exp_data[$];
   logic [3:0] exp_last[$];

   task automatic build_expect(input logic [3:0] a, input int n);
      logic [3:0] ad;
      exp_addr.delete(); exp_data.delete(); exp_last.delete();
      for (int i = 0; i < n; i++) begin
         ad = 4'((int'(a) + i) % 16);
         exp_addr.push_back(ad);
         exp_data.push_back(ad ^ 4'hA);
         exp_last.push_back((i == n - 1) ? 4'd1 : 4'd0);
      end
   endtask

   function automatic int first_diff(input logic [3:0] got[$], input logic [3:0] expv[$]);
      if (got.size() != expv.size()) return -2;
      foreach (got[i]) if (got[i] !== expv[i]) return i;
      return -1;
   endfunction

   function automatic bit consecutive(input int q[$]);
      foreach (q[i]) if (q[i] != q[0] + i) return 0;
      return 1;
   endfunction

   task automatic clear_mon();
      clr_req = 1'b1;
      @(negedge clk); #1;
      clr_req = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic issue_start(input logic [3:0] a, input logic [4:0] n);
      start = 1'b1; start_addr = a; len = n;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // mode 1: out_ready held high, mode 2: random out_ready
   task automatic wait_done(input int mode, input int budget, input string tag);
      int k = 0;
      while (done_cnt == 0 && k < budget) begin
         out_ready = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         k++;
      end
      out_ready = 1'b0;
      n_checks++;
      if (done_cnt == 0) begin
         n_fail++;
         $display("FAIL %s_timeout: done count %0d after %0d cycles, required 1", tag, done_cnt, budget);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk); #1;
      n_checks++;
      if ({busy, done, rom_en, rom_addr, out_valid, out_data, out_last} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b en=%b addr=%h valid=%b data=%h last=%b, required all 0",
                  busy, done, rom_en, rom_addr, out_valid, out_data, out_last);
      end
      rst = 1'b0;
      repeat (3) @(posedge clk); #1;
      n_checks++;
      if ({busy, rom_en, out_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_idle: got busy=%b en=%b valid=%b, required 000", busy, rom_en, out_valid);
      end
   endtask

   task automatic test_basic();
      build_expect(4'hA, 3);
      clear_mon();
      out_ready = 1'b1;
      issue_start(4'hA, 5'd3);
      wait_done(1, 60, "basic");
      repeat (2) @(posedge clk); #1;
      n_checks++;
      if (first_diff(mon_addr, exp_addr) != -1) begin
         n_fail++; $display("FAIL basic_addr: got %p, required %p", mon_addr, exp_addr);
      end
      n_checks++;
      if (!consecutive(mon_en_cyc)) begin
         n_fail++; $display("FAIL basic_addr_cycles: rom_en cycles %p, required consecutive", mon_en_cyc);
      end
      n_checks++;
      if (first_diff(mon_data, exp_data) != -1) begin
         n_fail++; $display("FAIL basic_data: got %p, required %p", mon_data, exp_data);
      end
      n_checks++;
      if (first_diff(mon_last, exp_last) != -1) begin
         n_fail++; $display("FAIL basic_last: got %p, required %p", mon_last, exp_last);
      end
      n_checks++;
      if (!consecutive(mon_hs_cyc)) begin
         n_fail++; $display("FAIL basic_throughput: handshake cycles %p, required consecutive", mon_hs_cyc);
      end
      n_checks++;
      if (done_cyc != last_hs_cyc + 1 || done_cnt != 1) begin
         n_fail++; $display("FAIL basic_done: done at %0d (count %0d), required at %0d (count 1)",
                            done_cyc, done_cnt, last_hs_cyc + 1);
      end
      n_checks++;
      if (!busy_at_last || busy_at_done || busy_cnt != done_cyc - first_busy_cyc) begin
         n_fail++; $display("FAIL basic_busy: busy cycles %0d, at_last=%b at_done=%b, required %0d,1,0",
                            busy_cnt, busy_at_last, busy_at_done, done_cyc - first_busy_cyc);
      end
   endtask

   task automatic test_wrap();
      build_expect(4'hE, 4);
      clear_mon();
      out_ready = 1'b1;
      issue_start(4'hE, 5'd4);
      wait_done(1, 60, "wrap");
      n_checks++;
      if (first_diff(mon_addr, exp_addr) != -1) begin
         n_fail++; $display("FAIL wrap_addr: got %p, required %p", mon_addr, exp_addr);
      end
      n_checks++;
      if (first_diff(mon_data, exp_data) != -1 || first_diff(mon_last, exp_last) != -1) begin
         n_fail++; $display("FAIL wrap_data: got %p last %p, required %p last %p",
                            mon_data, mon_last, exp_data, exp_last);
      end
   endtask

   task automatic test_backpressure();
      build_expect(4'h0, 8);
      clear_mon();
      out_ready = 1'b0;
      issue_start(4'h0, 5'd8);
      repeat (10) @(posedge clk);
      #1;
      n_checks++;
      if (mon_addr.size() != FIFO_DEPTH) begin
         n_fail++; $display("FAIL bp_issue_limit: got %0d rom_en pulses, required %0d", mon_addr.size(), FIFO_DEPTH);
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 4'hA || unstable) begin
         n_fail++; $display("FAIL bp_hold: valid=%b data=%h unstable=%b, required 1, A, 0", out_valid, out_data, unstable);
      end
      wait_done(1, 80, "bp");
      n_checks++;
      if (first_diff(mon_addr, exp_addr) != -1) begin
         n_fail++; $display("FAIL bp_addr: got %p, required %p", mon_addr, exp_addr);
      end
      n_checks++;
      if (first_diff(mon_data, exp_data) != -1 || first_diff(mon_last, exp_last) != -1) begin
         n_fail++; $display("FAIL bp_data: got %p last %p, required %p last %p", mon_data, mon_last, exp_data, exp_last);
      end
   endtask

   task automatic test_zero_and_busy();
      clear_mon();
      out_ready = 1'b1;
      issue_start(4'h5, 5'd0);
      repeat (5) @(posedge clk); #1;
      n_checks++;
      if (mon_addr.size() != 0 || valid_seen) begin
         n_fail++; $display("FAIL zero_quiet: got %0d reads, valid_seen=%b, required 0 and 0", mon_addr.size(), valid_seen);
      end
      n_checks++;
      if (done_cnt != 1 || busy_cnt != 1 || done_cyc != first_busy_cyc + 1) begin
         n_fail++; $display("FAIL zero_done: done count %0d busy cycles %0d done at %0d busy at %0d, required 1, 1, busy+1",
                            done_cnt, busy_cnt, done_cyc, first_busy_cyc);
      end
      build_expect(4'h2, 5);
      clear_mon();
      issue_start(4'h2, 5'd5);
      @(posedge clk); #1;
      issue_start(4'h9, 5'd3);
      wait_done(2, 120, "reject");
      repeat (6) @(posedge clk); #1;
      n_checks++;
      if (first_diff(mon_data, exp_data) != -1 || first_diff(mon_addr, exp_addr) != -1) begin
         n_fail++; $display("FAIL reject_words: got addr %p data %p, required addr %p data %p",
                            mon_addr, mon_data, exp_addr, exp_data);
      end
      n_checks++;
      if (done_cnt != 1 || busy !== 1'b0 || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reject_end: done count %0d busy=%b valid=%b, required 1, 0, 0", done_cnt, busy, out_valid);
      end
   endtask

   task automatic test_full_span();
      build_expect(4'h7, 16);
      clear_mon();
      issue_start(4'h7, 5'd16);
      wait_done(2, 300, "span");
      n_checks++;
      if (first_diff(mon_addr, exp_addr) != -1) begin
         n_fail++; $display("FAIL span_addr: got %p, required %p", mon_addr, exp_addr);
      end
      n_checks++;
      if (first_diff(mon_data, exp_data) != -1 || first_diff(mon_last, exp_last) != -1) begin
         n_fail++; $display("FAIL span_data: got %p last %p, required %p last %p", mon_data, mon_last, exp_data, exp_last);
      end
      n_checks++;
      if (unstable) begin
         n_fail++; $display("FAIL span_stable: output changed under backpressure (unstable=%b), required 0", unstable);
      end
   endtask

   task automatic test_reset_mid_burst();
      clear_mon();
      out_ready = 1'b1;
      issue_start(4'h0, 5'd8);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, rom_en, rom_addr, out_valid, out_data, out_last} !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got busy=%b done=%b en=%b addr=%h valid=%b data=%h last=%b, required all 0",
                  busy, done, rom_en, rom_addr, out_valid, out_data, out_last);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      clear_mon();
      repeat (6) @(posedge clk); #1;
      n_checks++;
      if (valid_seen || mon_addr.size() != 0 || done_cnt != 0) begin
         n_fail++; $display("FAIL midreset_quiet: valid_seen=%b reads=%0d done=%0d, required 0,0,0",
                            valid_seen, mon_addr.size(), done_cnt);
      end
      build_expect(4'h3, 2);
      clear_mon();
      issue_start(4'h3, 5'd2);
      wait_done(1, 60, "midreset");
      n_checks++;
      if (first_diff(mon_data, exp_data) != -1 || first_diff(mon_last, exp_last) != -1) begin
         n_fail++; $display("FAIL midreset_words: got %p last %p, required %p last %p", mon_data, mon_last, exp_data, exp_last);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_and_busy();
      test_full_span();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
